alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Command-issue and writeback controller sitting directly upstream of the combinational 8-bit ALU (`alu`). It owns a small 8-bit register file and accepts ALU commands over a valid/ready handshake. For each command it drives registered operands and op-select into the ALU, captures the ALU result and the five status flags, optionally writes the result back, and returns it over a second valid/ready handshake.

## Interface
- `NREG`, 4, number of 8-bit registers.
- `RW`, 2, register index width; must satisfy 2^RW = NREG.

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can accept a command
- `cmd_sel`  in  4  ALU op-select, passed unmodified to `alu_sel`
- `cmd_ra`  in  RW  register index for operand A
- `cmd_rb`  in  RW  register index for operand B
- `cmd_rd`  in  RW  destination register index
- `cmd_imm_en`  in  1  1: operand B = `cmd_imm`; 0: operand B = reg[`cmd_rb`]
- `cmd_imm`  in  8  immediate operand
- `cmd_wb`  in  1  1: write result to reg[`cmd_rd`]; 0: flags only
- `alu_a`, `alu_b`  out  8  registered ALU operands
- `alu_sel`  out  4  registered ALU op-select
- `alu_out`  in  8  ALU result
- `alu_ac`, `alu_c`, `alu_z`, `alu_s`, `alu_p`  in  1 each  ALU flags
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  8  captured result
- `rsp_flags`  out  5  captured flags {ac,c,z,s,p}, bit 4 = ac
- `flags`  out  5  persistent flag register, same bit order
- `ld_en`  in  1  direct register load strobe
- `ld_rd`  in  RW  load index
- `ld_data`  in  8  load data
- `dbg_idx`  in  RW  debug read index
- `dbg_data`  out  8  combinational read of reg[`dbg_idx`]

## Operation
- FSM states:
  - IDLE: `cmd_ready` = 1. On `cmd_valid & cmd_ready`, latch `alu_a` = reg[ra], `alu_b` = imm or reg[rb], `alu_sel` = `cmd_sel`, plus rd and wb, then go to ISSUE.
  - ISSUE: one cycle for the ALU to settle. At the end of the cycle, capture `alu_out` into `rsp_data` and the flags into `rsp_flags` and `flags`. If wb = 1, write reg[rd] = `alu_out`. Go to RESP.
  - RESP: `rsp_valid` = 1. On `rsp_valid & rsp_ready`, go to IDLE.
- `cmd_ready` is 1 only in IDLE and is forced to 0 while `rst` = 1. `cmd_valid` outside IDLE is ignored.
- `flags` updates on every capture, regardless of wb.
- Operand reads sample the register file before the acceptance edge. A write landing on that same edge is not seen by the command.
- `ld_en` is accepted in any state. If `ld_en` and the ALU writeback target the same register on the same edge, the writeback wins and the load is dropped. If they target different registers, both writes occur.
- `rsp_data` and `rsp_flags` hold stable throughout RESP.
- `alu_a`, `alu_b` and `alu_sel` hold their last values outside ISSUE.

## Timing
- Reset values: all registers 0, `flags` 0, `alu_a`/`alu_b`/`alu_sel` 0, `rsp_valid` 0, `rsp_data`/`rsp_flags` 0, state IDLE.
- Acceptance at edge T:
  - `alu_*` show the new operands from T+1.
  - Capture and writeback occur at edge T+2.
  - `rsp_valid` = 1 from T+2.
- Response latency is 2 cycles. With `rsp_ready` held at 1, a new command is accepted no earlier than edge T+3, so minimum spacing is 3 cycles per command.
- `rst` mid-operation (ISSUE or RESP) means:
  - The next state is IDLE.
  - No writeback occurs, and the pending `flags` update does not happen.
  - `rsp_valid` = 0 in the following cycle.
  - All state returns to reset values.

## Test plan
Bench ALU stub: sel 0 gives a+b mod 256, sel 1 gives a−b mod 256; the stub computes the flags.

- Reset: hold `rst` for 2 cycles, then release. Required: `cmd_ready` = 0 during reset and 1 in the first cycle after release; `dbg_data` = 0 for all indices; `rsp_valid` = 0; `flags` = 0.
- Add with writeback: load r0 = 0x0A and r1 = 0x8F; send sel = 0, ra = 0, rb = 1, rd = 2, wb = 1. Required: at T+1, `alu_a` = 0x0A, `alu_b` = 0x8F, `alu_sel` = 0; at T+2, `rsp_valid` = 1 and `rsp_data` = 0x99; afterwards `dbg_data`[2] = 0x99.
- Immediate compare: with r0 = 0x0A, send sel = 1, ra = 0, imm_en = 1, imm = 0x0A, wb = 0, rd = 3. Required: `rsp_data` = 0x00, `flags` z = 1, r3 unchanged.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles while pulsing `cmd_valid`. Required: `rsp_data`/`rsp_flags` stable, `cmd_ready` = 0, no second command accepted; after the handshake, `cmd_ready` = 1 on the next cycle.
- Collision: `ld_en` with `ld_rd` = 2 and `ld_data` = 0x55 on the same edge as a writeback of 0x99 to r2. Required: r2 = 0x99. Repeat with `ld_rd` = 1: r1 = 0x55 and r2 = 0x99.
- Reset mid-op: assert `rst` in ISSUE of an add targeting r2 (previously 0x11). Required: r2 stays 0 (reset value), `rsp_valid` stays 0, `flags` = 0, and IDLE is reached after `rst` drops.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Command-issue and writeback controller placed directly upstream of the
// combinational 8-bit ALU. It owns a small register file, accepts ALU commands
// over a valid/ready handshake, drives registered operands and op-select into
// the ALU, captures the ALU result plus five status flags, optionally writes
// the result back, and returns it over a second valid/ready handshake.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid / cmd_ready          command handshake
//   cmd_sel, cmd_ra, cmd_rb,       op-select, operand A/B register indices,
//   cmd_rd, cmd_imm_en, cmd_imm,   destination, immediate select and value,
//   cmd_wb                         writeback enable
//   alu_a, alu_b, alu_sel          registered ALU operands and op-select
//   alu_out, alu_ac .. alu_p       ALU result and flags
//   rsp_valid / rsp_ready          response handshake
//   rsp_data, rsp_flags            captured result and flags {ac,c,z,s,p}
//   flags                          persistent flag register {ac,c,z,s,p}
//   ld_en, ld_rd, ld_data          direct register load port
//   dbg_idx, dbg_data              combinational register read port
module alu_issue_ctrl #(
  parameter int NREG = 4,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_sel,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic [RW-1:0] cmd_rd,
  input  logic          cmd_imm_en,
  input  logic [7:0]    cmd_imm,
  input  logic          cmd_wb,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [7:0]    alu_out,
  input  logic          alu_ac,
  input  logic          alu_c,
  input  logic          alu_z,
  input  logic          alu_s,
  input  logic          alu_p,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [4:0]    rsp_flags,
  output logic [4:0]    flags,
  input  logic          ld_en,
  input  logic [RW-1:0] ld_rd,
  input  logic [7:0]    ld_data,
  input  logic [RW-1:0] dbg_idx,
  output logic [7:0]    dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      regs_q [NREG];
  logic [RW-1:0]   rd_q;
  logic            wb_q;
  logic            accept;
  logic            capture;
  logic [4:0]      alu_flags;

  // Handshake decode. cmd_ready is masked by rst so nothing is offered as
  // acceptable while the block is being reset. capture marks the edge that
  // ends the ISSUE cycle, by which time the ALU has settled on the operands.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state_q == ISSUE);
  assign alu_flags = {alu_ac, alu_c, alu_z, alu_s, alu_p};
  assign dbg_data  = regs_q[dbg_idx];

  // Next-state logic: IDLE waits for a command, ISSUE always lasts exactly
  // one cycle, and RESP holds until the consumer takes the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset from any state, including mid-operation, lands in
  // IDLE so a pending capture or response is simply abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch and result capture. Operands are read from the register
  // file as it stands before the acceptance edge, so a write landing on that
  // same edge is not seen. The ALU-facing registers only change on accept,
  // which keeps them stable outside ISSUE. Reset takes priority over capture,
  // which is what suppresses the flag update when reset hits during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_sel   <= 4'd0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_flags <= 5'd0;
      flags     <= 5'd0;
    end else begin
      if (accept) begin
        alu_a   <= regs_q[cmd_ra];
        alu_b   <= cmd_imm_en ? cmd_imm : regs_q[cmd_rb];
        alu_sel <= cmd_sel;
        rd_q    <= cmd_rd;
        wb_q    <= cmd_wb;
      end
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_flags <= alu_flags;
        flags     <= alu_flags;
      end
    end
  end

  // Register file. Each entry picks exactly one write source per edge: the
  // ALU writeback has priority over a direct load to the same index, while
  // loads to any other index proceed in parallel with the writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (capture && wb_q && (rd_q == RW'(i))) begin
          regs_q[i] <= alu_out;
        end else if (ld_en && (ld_rd == RW'(i))) begin
          regs_q[i] <= ld_data;
        end
      end
    end
  end

endmodule
